// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and requester ids.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational pick between the CPU (req[0]) and loader (req[1]) ports.
// DM_ARB_CPU_PRIORITY_EN selects fixed CPU priority instead of round-robin.
module rr_arbiter2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
`ifndef DM_ARB_CPU_PRIORITY_EN
    input  logic       last_winner,
`endif
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = REQ_CPU;
`ifdef DM_ARB_CPU_PRIORITY_EN
        if (!req[0] && req[1]) begin
            winner = REQ_LDR;
        end
`else
        // On contention the port that did not win last time goes next.
        if (req == 2'b11) begin
            winner = ~last_winner;
        end else if (req[1]) begin
            winner = REQ_LDR;
        end
`endif
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port synchronous data memory between the CPU and the loader port.
// Build option DM_ARB_CPU_PRIORITY_EN: CPU always wins instead of round-robin.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MemSize  = 10,
    parameter int DataSize = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [MemSize-1:0]  cpu_addr,
    input  logic [DataSize-1:0] cpu_wdata,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    input  logic                ldr_req,
    input  logic                ldr_we,
    input  logic [MemSize-1:0]  ldr_addr,
    input  logic [DataSize-1:0] ldr_wdata,
    output logic                ldr_gnt,
    output logic                ldr_rvalid,
    output logic [DataSize-1:0] rdata,
    input  logic [DataSize-1:0] DM_out,
    output logic                enable_dm,
    output logic                enable_dm_fetch,
    output logic                enable_dm_write,
    output logic [MemSize-1:0]  DM_address,
    output logic [DataSize-1:0] DM_in,
    output logic                busy
);

    state_e                state_q, state_d;
    logic                  win_q, win_d;
    logic                  we_q, we_d;
    logic [MemSize-1:0]    addr_q, addr_d;
    logic [DataSize-1:0]   wdata_q, wdata_d;
    logic                  pick_winner;
    logic                  pick_valid;

`ifndef DM_ARB_CPU_PRIORITY_EN
    logic                  last_winner_q, last_winner_d;
`endif

    rr_arbiter2 u_pick (
        .req         ({ldr_req, cpu_req}),
`ifndef DM_ARB_CPU_PRIORITY_EN
        .last_winner (last_winner_q),
`endif
        .winner      (pick_winner),
        .valid       (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifndef DM_ARB_CPU_PRIORITY_EN
        last_winner_d = last_winner_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Requests are only sampled here; the latched copy drives the whole access.
                if (pick_valid) begin
                    win_d   = pick_winner;
                    we_d    = (pick_winner == REQ_LDR) ? ldr_we    : cpu_we;
                    addr_d  = (pick_winner == REQ_LDR) ? ldr_addr  : cpu_addr;
                    wdata_d = (pick_winner == REQ_LDR) ? ldr_wdata : cpu_wdata;
                    state_d = ACCESS;
`ifndef DM_ARB_CPU_PRIORITY_EN
                    last_winner_d = pick_winner;
`endif
                end
            end
            ACCESS:  state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt         = 1'b0;
        ldr_gnt         = 1'b0;
        cpu_rvalid      = 1'b0;
        ldr_rvalid      = 1'b0;
        rdata           = '0;
        enable_dm       = 1'b0;
        enable_dm_fetch = 1'b0;
        enable_dm_write = 1'b0;
        DM_address      = '0;
        DM_in           = '0;
        busy            = (state_q != IDLE);
        unique case (state_q)
            ACCESS: begin
                cpu_gnt         = (win_q == REQ_CPU);
                ldr_gnt         = (win_q == REQ_LDR);
                enable_dm       = 1'b1;
                enable_dm_write = we_q;
                enable_dm_fetch = ~we_q;
                DM_address      = addr_q;
                DM_in           = wdata_q;
            end
            RESP: begin
                cpu_rvalid = (win_q == REQ_CPU);
                ldr_rvalid = (win_q == REQ_LDR);
                rdata      = DM_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= REQ_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifndef DM_ARB_CPU_PRIORITY_EN
            last_winner_q <= REQ_LDR;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifndef DM_ARB_CPU_PRIORITY_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural synchronous data memory.
module tb_dm_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [9:0]  cpu_addr, ldr_addr;
    logic [31:0] cpu_wdata, ldr_wdata;
    logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
    logic [31:0] rdata;
    logic [31:0] DM_out;
    logic        enable_dm, enable_dm_fetch, enable_dm_write;
    logic [9:0]  DM_address;
    logic [31:0] DM_in;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:1023];

    always #5 clock = ~clock;

    dm_port_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
        .rdata(rdata), .DM_out(DM_out),
        .enable_dm(enable_dm), .enable_dm_fetch(enable_dm_fetch), .enable_dm_write(enable_dm_write),
        .DM_address(DM_address), .DM_in(DM_in), .busy(busy)
    );

    // Behavioural DM: write and read both registered on the rising edge.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
        DM_out = '0;
    end
    always @(posedge clock) begin
        if (enable_dm && enable_dm_write) mem[DM_address] <= DM_in;
        if (enable_dm && enable_dm_fetch) DM_out <= mem[DM_address];
    end

    // Mutual exclusion of grants and read-valids, checked every cycle.
    always @(negedge clock) begin
        n_cmp++;
        if ((cpu_gnt && ldr_gnt) || (cpu_rvalid && ldr_rvalid)) begin
            n_err++;
            $display("FAIL excl: gnt=%b%b rvalid=%b%b required not both", cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid);
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, enable_dm, enable_dm_fetch, enable_dm_write, busy} !== 8'b0
            || DM_address !== 10'h0 || DM_in !== 32'h0 || rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: ctrl=%b addr=%h din=%h rdata=%h required all 0",
                {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, enable_dm, enable_dm_fetch, enable_dm_write, busy},
                DM_address, DM_in, rdata);
        end
        reset = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_ldr_write();
        ldr_req = 1; ldr_we = 1; ldr_addr = 10'h005; ldr_wdata = 32'hDEADBEEF;
        @(negedge clock);
        n_cmp++;
        if ({ldr_gnt, cpu_gnt, enable_dm, enable_dm_write, enable_dm_fetch, busy} !== 6'b101101
            || DM_address !== 10'h005 || DM_in !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL ldr_write_access: gnt/en/wr/fe/busy=%b addr=%h din=%h required 101101 005 deadbeef",
                {ldr_gnt, cpu_gnt, enable_dm, enable_dm_write, enable_dm_fetch, busy}, DM_address, DM_in);
        end
        ldr_req = 0;
        @(negedge clock);
        n_cmp++;
        if ({busy, ldr_gnt, ldr_rvalid, enable_dm} !== 4'b0) begin
            n_err++;
            $display("FAIL ldr_write_done: busy/gnt/rvalid/en=%b required 0000", {busy, ldr_gnt, ldr_rvalid, enable_dm});
        end
        $display("ldr write addr=005 data=deadbeef");
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
        @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, ldr_gnt, enable_dm, enable_dm_fetch, enable_dm_write} !== 5'b10110 || DM_address !== 10'h005) begin
            n_err++;
            $display("FAIL cpu_read_access: gnt/en/fe/wr=%b addr=%h required 10110 005",
                {cpu_gnt, ldr_gnt, enable_dm, enable_dm_fetch, enable_dm_write}, DM_address);
        end
        cpu_req = 0;
        @(negedge clock);
        n_cmp++;
        if ({cpu_rvalid, ldr_rvalid, enable_dm, busy} !== 4'b1001 || rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL cpu_read_resp: rv/lrv/en/busy=%b rdata=%h required 1001 deadbeef",
                {cpu_rvalid, ldr_rvalid, enable_dm, busy}, rdata);
        end
        @(negedge clock);
        n_cmp++;
        if ({busy, cpu_rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL cpu_read_done: busy/rvalid=%b required 00", {busy, cpu_rvalid});
        end
        $display("cpu read addr=005 rdata=%h", rdata);
    endtask

    task automatic test_round_robin();
        logic exp_ldr;
        reset = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h001;
        ldr_req = 1; ldr_we = 0; ldr_addr = 10'h002;
        @(negedge clock);
        reset = 0;
        for (int g = 0; g < 4; g++) begin
            int k = 0;
            @(negedge clock);
            while (!(cpu_gnt || ldr_gnt) && k < 10) begin
                @(negedge clock);
                k++;
            end
`ifdef DM_ARB_CPU_PRIORITY_EN
            exp_ldr = 1'b0;
`else
            exp_ldr = (g % 2) == 1;
`endif
            n_cmp++;
            if (k >= 10 || ldr_gnt !== exp_ldr || cpu_gnt !== !exp_ldr
                || DM_address !== (exp_ldr ? 10'h002 : 10'h001)) begin
                n_err++;
                $display("FAIL rr_grant%0d: cpu_gnt=%b ldr_gnt=%b addr=%h wait=%0d required ldr=%b", g,
                    cpu_gnt, ldr_gnt, DM_address, k, exp_ldr);
            end
            if (g == 3) begin
                cpu_req = 0;
                ldr_req = 0;
            end
            @(negedge clock);
            n_cmp++;
            if (ldr_rvalid !== exp_ldr || cpu_rvalid !== !exp_ldr
                || rdata !== (exp_ldr ? 32'hA500_0002 : 32'hA500_0001)) begin
                n_err++;
                $display("FAIL rr_resp%0d: cpu_rv=%b ldr_rv=%b rdata=%h required ldr=%b", g,
                    cpu_rvalid, ldr_rvalid, rdata, exp_ldr);
            end
            $display("rr grant %0d to %s rdata=%h", g, ldr_gnt || ldr_rvalid ? "LDR" : "CPU", rdata);
        end
        @(negedge clock);
    endtask

    task automatic test_max_addr();
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h3FF; cpu_wdata = 32'h1234_5678;
        @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, enable_dm_write} !== 2'b11 || DM_address !== 10'h3FF || DM_in !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL max_write: gnt/wr=%b addr=%h din=%h required 11 3ff 12345678",
                {cpu_gnt, enable_dm_write}, DM_address, DM_in);
        end
        cpu_req = 0;
        @(negedge clock);
        n_cmp++;
        if ({cpu_rvalid, ldr_rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL max_write_norv: rvalid=%b required 00", {cpu_rvalid, ldr_rvalid});
        end
        ldr_req = 1; ldr_we = 0; ldr_addr = 10'h3FF;
        @(negedge clock);
        n_cmp++;
        if ({ldr_gnt, enable_dm_fetch} !== 2'b11 || DM_address !== 10'h3FF) begin
            n_err++;
            $display("FAIL max_read_access: gnt/fe=%b addr=%h required 11 3ff", {ldr_gnt, enable_dm_fetch}, DM_address);
        end
        ldr_req = 0;
        @(negedge clock);
        n_cmp++;
        if ({ldr_rvalid, cpu_rvalid} !== 2'b10 || rdata !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL max_read_resp: rv=%b rdata=%h required 10 12345678", {ldr_rvalid, cpu_rvalid}, rdata);
        end
        $display("max addr 3ff round trip rdata=%h", rdata);
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
        @(negedge clock);
        n_cmp++;
        if (cpu_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_gnt: cpu_gnt=%b required 1", cpu_gnt);
        end
        reset = 1;
        cpu_req = 0;
        @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, enable_dm, enable_dm_fetch, enable_dm_write, busy} !== 8'b0) begin
            n_err++;
            $display("FAIL rst_mid_abort: ctrl=%b required 00000000",
                {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, enable_dm, enable_dm_fetch, enable_dm_write, busy});
        end
        reset = 0;
        cpu_req = 1; cpu_addr = 10'h001;
        ldr_req = 1; ldr_we = 0; ldr_addr = 10'h002;
        @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, ldr_gnt, cpu_rvalid} !== 3'b100) begin
            n_err++;
            $display("FAIL rst_mid_next: cpu_gnt/ldr_gnt/cpu_rv=%b required 100", {cpu_gnt, ldr_gnt, cpu_rvalid});
        end
        cpu_req = 0;
        ldr_req = 0;
        $display("reset mid-read aborted, next grant cpu=%b", cpu_gnt);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_addr_change();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
        @(negedge clock);
        cpu_addr = 10'h020;
        cpu_req = 0;
        #1;
        n_cmp++;
        if (cpu_gnt !== 1'b1 || DM_address !== 10'h010) begin
            n_err++;
            $display("FAIL addr_hold: gnt=%b addr=%h required 1 010", cpu_gnt, DM_address);
        end
        @(negedge clock);
        n_cmp++;
        if (cpu_rvalid !== 1'b1 || rdata !== 32'hA500_0010) begin
            n_err++;
            $display("FAIL addr_hold_resp: rv=%b rdata=%h required 1 a5000010", cpu_rvalid, rdata);
        end
        $display("addr change during access, read 010 rdata=%h", rdata);
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_ldr_write();
        test_cpu_read();
        test_round_robin();
        test_max_addr();
        test_reset_mid();
        test_addr_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
